dec_nx2n_bist: RTL and testbench
================================

# dec_nx2n_bist

Parametrised, registered N-to-2^N one-hot decoder with run-time fault injection and a built-in self-test (BIST) sequencer. It generalises the fixed 4x16 fault-variant decoders into a single block. The injection point is selectable at run time instead of being baked into separate modules. The block sweeps every input code and reports whether the output was one-hot and correct. It sits between the select logic and the downstream enables, and doubles as the fault-coverage vehicle for the decoder test suite.

## Interface
- N, default 4: select width; output width is 2^N.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  functional decode enable; all-zero output when low.
- sel  in  N  functional select code.
- inj_type  in  2  fault type: 00 none, 01 stuck-at-0, 10 stuck-at-1, 11 invert.
- inj_line  in  N  index of the output line the fault applies to.
- start  in  1  BIST start request, level-sampled in IDLE only.
- D  out  2^N  registered decoder output.
- busy  out  1  high while BIST owns the decoder.
- done  out  1  one-cycle pulse when BIST completes.
- pass  out  1  last BIST had zero mismatches; held until next start.
- err_cnt  out  N+1  mismatch count of the last BIST.
- first_fail  out  N  code of the first mismatch; 0 if none.

## Operation
- Core: nxt = en_i ? (1 << sel_i) : 0; fault applied to line inj_line of nxt (SA0 forces 0, SA1 forces 1, invert flips); D <= faulted nxt.
- Functional mode (not busy): sel_i = sel, en_i = en.
- BIST mode (busy): sel_i = sweep counter, en_i = 1; external sel/en ignored.
- Fault inputs are sampled every cycle in both modes, never latched; changing them mid-BIST affects only the codes decoded afterwards.
- FSM states:
  - IDLE: start=1 → RUN; clear cnt, err_cnt, first_fail, fail_seen, pass.
  - RUN: issue code cnt; cnt++; after code 2^N-1 → DRAIN.
  - DRAIN: check the last code → REPORT.
  - REPORT: done=1, pass = (err_cnt==0) → IDLE.
- Checker: the issued code is delayed one cycle (exp_code, exp_vld). When exp_vld is high, compare D with 1<<exp_code.
- On mismatch: err_cnt++. If !fail_seen, capture first_fail=exp_code and set fail_seen.
- err_cnt saturation is unnecessary; the maximum is 2^N, which fits in N+1 bits.
- start is ignored while busy; start held high re-triggers BIST on the cycle after REPORT.

## Timing
- Reset values: D=0, busy=0, done=0, pass=0, err_cnt=0, first_fail=0, FSM=IDLE, cnt=0.
- Functional latency is 1 cycle, sel/en to D.
- If start is sampled at edge k: busy=1 from edge k to edge k+2^N+2.
  - Codes 0..2^N-1 are issued in cycles k+1..k+2^N and appear on D one edge later.
  - done pulses for exactly the cycle after edge k+2^N+1; busy falls with it.
  - For N=4, done is high 17 cycles after start is sampled.
- pass, err_cnt and first_fail are valid with done and stable until the next start is accepted.
- Reset mid-BIST aborts immediately: all outputs return to their reset values and no done is issued.
- Simultaneous start and reset: reset wins.

## Structure
- Package dec_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, REPORT);
  - the inj_type encodings (INJ_NONE, INJ_SA0, INJ_SA1, INJ_INV);
  - a function returning the one-hot expectation for a code.
- Sub-module dec_core holds the registered decoder plus the fault-injection mux, parametrised by N.
- The top level holds the FSM, sweep counter, expectation pipeline and result registers.

## Test plan
- Functional, N=4, no fault: sel=5, en=1 → D=16'h0020 one cycle later; en=0 → D=0.
- Clean BIST, inj_type=00: start pulse → done 17 cycles later; pass=1, err_cnt=0, first_fail=0.
- SA0 on line 9 → pass=0, err_cnt=1, first_fail=9.
- SA1 on line 3 → err_cnt=15 (every code except 3 gains an extra bit), first_fail=0.
- Invert on line 0 → err_cnt=16, first_fail=0.
- Reset asserted during RUN at code 6 → immediate reset values and no done pulse; a following start gives a clean 17-cycle run.
- start held high through the whole run → restarts immediately after REPORT.
- Functional sel/en toggling during BIST → no effect on the sweep result.

Source files
------------

// File: rtl/dec_nx2n_bist_pkg.sv
// Shared types and helpers for the N-to-2^N decoder with fault injection and BIST.
package dec_pkg;

  localparam int MAX_N = 8;
  localparam int MAX_W = 2 ** MAX_N;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    INJ_NONE = 2'b00,
    INJ_SA0  = 2'b01,
    INJ_SA1  = 2'b10,
    INJ_INV  = 2'b11
  } inj_t;

  // Callers truncate to their own 2^N width with a size cast.
  function automatic logic [MAX_W-1:0] onehot(input logic [MAX_N-1:0] code);
    return MAX_W'(1) << code;
  endfunction

endpackage

// File: rtl/dec_nx2n_bist_if.sv
// Decoder/BIST signal bundle; master drives selects, faults and start.
interface dec_nx2n_bist_if #(parameter int N = 4);
  logic            en;
  logic [N-1:0]    sel;
  logic [1:0]      inj_type;
  logic [N-1:0]    inj_line;
  logic            start;
  logic [2**N-1:0] D;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N:0]      err_cnt;
  logic [N-1:0]    first_fail;

  modport master (
    output en, sel, inj_type, inj_line, start,
    input  D, busy, done, pass, err_cnt, first_fail
  );

  modport slave (
    input  en, sel, inj_type, inj_line, start,
    output D, busy, done, pass, err_cnt, first_fail
  );
endinterface

// File: rtl/dec_nx2n_bist_core.sv
// Registered one-hot decoder with a run-time single-line fault injection mux.
module dec_core
  import dec_pkg::*;
#(
  parameter int N = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_en,
  input  logic [N-1:0]    i_sel,
  input  logic [1:0]      i_inj_type,
  input  logic [N-1:0]    i_inj_line,
  output logic [2**N-1:0] o_d
);
  localparam int W = 2 ** N;

  logic [W-1:0] w_nxt;
  logic [W-1:0] w_flt;

  always_comb begin
    w_nxt = i_en ? W'(onehot(MAX_N'(i_sel))) : '0;
    w_flt = w_nxt;
    case (inj_t'(i_inj_type))
      INJ_SA0: w_flt[i_inj_line] = 1'b0;
      INJ_SA1: w_flt[i_inj_line] = 1'b1;
      INJ_INV: w_flt[i_inj_line] = ~w_nxt[i_inj_line];
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) o_d <= '0;
    else     o_d <= w_flt;
  end
endmodule

// File: rtl/dec_nx2n_bist.sv
// Decoder top: BIST sequencer sweeps every code through dec_core and scores D.
module dec_nx2n_bist
  import dec_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  dec_nx2n_bist_if.slave bus
);
  localparam int W = 2 ** N;

  state_t       r_state, w_state_nxt;
  logic         w_start_acc;
  logic [N-1:0] r_cnt;
  logic [N-1:0] r_exp_code;
  logic         r_exp_vld;
  logic [N:0]   r_err_cnt;
  logic [N:0]   w_err_nxt;
  logic [N-1:0] r_first_fail;
  logic         r_fail_seen;
  logic         r_pass;
  logic         w_busy;
  logic         w_en_i;
  logic [N-1:0] w_sel_i;
  logic [W-1:0] w_d;
  logic         w_mismatch;

  assign w_busy  = (r_state != IDLE);
  assign w_sel_i = w_busy ? r_cnt : bus.sel;
  assign w_en_i  = w_busy | bus.en;

  dec_core #(.N(N)) u_core (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_en_i),
    .i_sel      (w_sel_i),
    .i_inj_type (bus.inj_type),
    .i_inj_line (bus.inj_line),
    .o_d        (w_d)
  );

  // D lags the issued code by one edge, so the check runs against the delayed copy.
  assign w_mismatch = r_exp_vld && (w_d != W'(onehot(MAX_N'(r_exp_code))));
  assign w_err_nxt  = r_err_cnt + (N+1)'(w_mismatch);

  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    case (r_state)
      IDLE: if (bus.start) begin
        w_state_nxt = RUN;
        w_start_acc = 1'b1;
      end
      RUN:     if (r_cnt == '1) w_state_nxt = DRAIN;
      DRAIN:   w_state_nxt = REPORT;
      REPORT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_exp_code <= '0;
      r_exp_vld  <= 1'b0;
    end else begin
      if (w_start_acc)        r_cnt <= '0;
      else if (r_state == RUN) r_cnt <= r_cnt + 1'b1;
      r_exp_code <= r_cnt;
      r_exp_vld  <= (r_state == RUN);
    end
  end

  // pass is decided on the DRAIN edge so it is valid alongside done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt    <= '0;
      r_first_fail <= '0;
      r_fail_seen  <= 1'b0;
      r_pass       <= 1'b0;
    end else if (w_start_acc) begin
      r_err_cnt    <= '0;
      r_first_fail <= '0;
      r_fail_seen  <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      if (w_mismatch) begin
        r_err_cnt <= w_err_nxt;
        if (!r_fail_seen) begin
          r_first_fail <= r_exp_code;
          r_fail_seen  <= 1'b1;
        end
      end
      if (r_state == DRAIN) r_pass <= (w_err_nxt == '0);
    end
  end

  assign bus.D          = w_d;
  assign bus.busy       = w_busy;
  assign bus.done       = (r_state == REPORT);
  assign bus.pass       = r_pass;
  assign bus.err_cnt    = r_err_cnt;
  assign bus.first_fail = r_first_fail;
endmodule

// File: tb/tb_dec_nx2n_bist.sv
// Self-checking bench for dec_nx2n_bist (N=4): vector table, random decode, BIST sweeps.
module tb_dec_nx2n_bist;
  localparam int N = 4;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  dec_nx2n_bist_if #(.N(N)) bus();

  dec_nx2n_bist #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          en;
    int          sel;
    int          t;
    int          line;
    logic [15:0] exp_d;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference decode: one-hot of sel (or zero), then one line forced/flipped.
  function automatic logic [W-1:0] model_d(input bit en, input int sel, input int t, input int line);
    logic [W-1:0] v;
    logic [W-1:0] m;
    v = en ? (W'(1) << sel) : '0;
    m = W'(1) << line;
    case (t)
      1:       v = v & ~m;
      2:       v = v | m;
      3:       v = v ^ m;
      default: ;
    endcase
    return v;
  endfunction

  task automatic model_bist(input int t, input int line, output int err, output int ff);
    bit seen = 0;
    err = 0;
    ff  = 0;
    for (int c = 0; c < W; c++) begin
      if (model_d(1'b1, c, t, line) != (W'(1) << c)) begin
        err++;
        if (!seen) begin
          ff   = c;
          seen = 1;
        end
      end
    end
  endtask

  task automatic run_bist(input int t, input int line, input bit hold, input string tag);
    int merr, mff, lat;
    model_bist(t, line, merr, mff);
    bus.inj_type = 2'(t);
    bus.inj_line = 4'(line);
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = hold;
    chk({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      bus.sel = 4'($urandom);
      bus.en  = 1'($urandom);
      @(posedge clk); #1;
      if (i <= W) chk($sformatf("%s_d%0d", tag, i-1), 32'(bus.D), 32'(model_d(1'b1, i-1, t, line)));
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_done_latency"}, 32'(lat), 32'(W + 1));
    chk({tag, "_pass"}, 32'(bus.pass), 32'(merr == 0));
    chk({tag, "_err_cnt"}, 32'(bus.err_cnt), 32'(merr));
    chk({tag, "_first_fail"}, 32'(bus.first_fail), 32'(mff));
    @(posedge clk); #1;
    chk({tag, "_busy_end"}, {31'd0, bus.busy, bus.done}, 32'd0);
    chk({tag, "_err_hold"}, 32'(bus.err_cnt), 32'(merr));
  endtask

  initial begin
    int t, l;
    bit saw_done;
    vecs[0]  = '{1, 5,  0, 0,  16'h0020};
    vecs[1]  = '{0, 5,  0, 0,  16'h0000};
    vecs[2]  = '{1, 0,  0, 0,  16'h0001};
    vecs[3]  = '{1, 15, 0, 0,  16'h8000};
    vecs[4]  = '{1, 9,  1, 9,  16'h0000};
    vecs[5]  = '{1, 9,  1, 3,  16'h0200};
    vecs[6]  = '{1, 3,  2, 3,  16'h0008};
    vecs[7]  = '{1, 4,  2, 3,  16'h0018};
    vecs[8]  = '{0, 0,  2, 7,  16'h0080};
    vecs[9]  = '{1, 0,  3, 0,  16'h0000};
    vecs[10] = '{1, 2,  3, 0,  16'h0005};
    vecs[11] = '{0, 0,  3, 15, 16'h8000};

    bus.en = 0; bus.sel = 0; bus.inj_type = 0; bus.inj_line = 0; bus.start = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_d", 32'(bus.D), 32'd0);
    chk("reset_flags", {29'd0, bus.busy, bus.done, bus.pass}, 32'd0);
    chk("reset_err", 32'(bus.err_cnt), 32'd0);
    chk("reset_ff", 32'(bus.first_fail), 32'd0);
    @(negedge clk) rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      bus.en = vecs[i].en; bus.sel = 4'(vecs[i].sel);
      bus.inj_type = 2'(vecs[i].t); bus.inj_line = 4'(vecs[i].line);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_d", i), 32'(bus.D), 32'(vecs[i].exp_d));
    end

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      bus.en = 1'($urandom); bus.sel = 4'($urandom);
      bus.inj_type = 2'($urandom); bus.inj_line = 4'($urandom);
      @(posedge clk); #1;
      chk($sformatf("rand%0d_d", i), 32'(bus.D),
          32'(model_d(bus.en, int'(bus.sel), int'(bus.inj_type), int'(bus.inj_line))));
    end

    @(posedge clk); #1;
    run_bist(0, 0,  0, "clean");
    run_bist(1, 9,  0, "sa0_9");
    run_bist(2, 3,  0, "sa1_3");
    run_bist(3, 0,  0, "inv_0");
    for (int i = 0; i < 4; i++) begin
      t = $urandom_range(0, 3);
      l = $urandom_range(0, W - 1);
      run_bist(t, l, 0, $sformatf("rbist%0d", i));
    end

    // Start held high: the second sweep begins on the first IDLE edge.
    run_bist(2, 12, 1, "hold_a");
    run_bist(0, 0,  0, "hold_b");

    // Reset mid-sweep while code 6 is being issued.
    bus.inj_type = 0;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_d", 32'(bus.D), 32'd0);
    chk("midrst_flags", {29'd0, bus.busy, bus.done, bus.pass}, 32'd0);
    chk("midrst_err", 32'(bus.err_cnt), 32'd0);
    bus.start = 1'b1;
    saw_done  = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) saw_done = 1;
    end
    chk("rst_beats_start", 32'(saw_done), 32'd0);
    bus.start = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", 32'(bus.busy), 32'd0);
    run_bist(0, 0, 0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
